switch_allocator: RTL and testbench

- Separable input-first switch allocator with round-robin fairness, one instance per router.
- Consumes per-VC switch requests, routed output ports and allocated downstream VCs from all input ports, plus downstream on/off status.
- Drives each input port's buffer-read select/valid and the crossbar's per-output input select.
- Allocates at most one flit per input port and one per output port each cycle.

---
 rtl/switch_allocator.sv | 137 +++++++++++++
 tb/tb_switch_allocator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input round-robin VC pick, then per-output
// round-robin input pick. Grants are combinational; only the round-robin pointers are state.
module switch_allocator #(
  parameter int unsigned PORT_NUM  = 5,
  parameter int unsigned VC_NUM    = 2,
  parameter int unsigned VC_SIZE   = $clog2(VC_NUM),
  parameter int unsigned PORT_SIZE = $clog2(PORT_NUM)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PORT_NUM*VC_NUM-1:0]           request_i,
  input  logic [PORT_NUM*VC_NUM*PORT_SIZE-1:0] out_port_i,
  input  logic [PORT_NUM*VC_NUM*VC_SIZE-1:0]   downstream_vc_i,
  input  logic [PORT_NUM*VC_NUM-1:0]           on_off_i,
  output logic [PORT_NUM-1:0]                  valid_o,
  output logic [PORT_NUM*VC_SIZE-1:0]          vc_sel_o,
  output logic [PORT_NUM-1:0]                  xb_valid_o,
  output logic [PORT_NUM*PORT_SIZE-1:0]        xb_sel_o,
  output logic [PORT_NUM*VC_SIZE-1:0]          xb_vc_o
);

  logic [VC_SIZE-1:0]         r_in_ptr      [PORT_NUM];
  logic [VC_SIZE-1:0]         w_in_ptr_nxt  [PORT_NUM];
  logic [PORT_SIZE-1:0]       r_out_ptr     [PORT_NUM];
  logic [PORT_SIZE-1:0]       w_out_ptr_nxt [PORT_NUM];

  logic [PORT_NUM*VC_NUM-1:0] w_elig;
  logic [PORT_NUM-1:0]        w_s1_valid;
  logic [VC_SIZE-1:0]         w_s1_vc       [PORT_NUM];
  logic [PORT_SIZE-1:0]       w_s1_port     [PORT_NUM];
  logic [VC_SIZE-1:0]         w_s1_dv       [PORT_NUM];

  logic [PORT_NUM-1:0]        w_grant;
  logic [PORT_NUM-1:0]        w_xb_hit;
  logic [PORT_SIZE-1:0]       w_xb_src      [PORT_NUM];

  // Out-of-range port/VC codes never index on_off_i; such VCs are simply ineligible.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < PORT_NUM * VC_NUM; i++) begin
      if (request_i[i] &&
          (int'(out_port_i[i*PORT_SIZE +: PORT_SIZE]) < PORT_NUM) &&
          (int'(downstream_vc_i[i*VC_SIZE +: VC_SIZE]) < VC_NUM)) begin
        w_elig[i] = on_off_i[int'(out_port_i[i*PORT_SIZE +: PORT_SIZE]) * VC_NUM +
                             int'(downstream_vc_i[i*VC_SIZE +: VC_SIZE])];
      end
    end
  end

  // Stage 1: per input, first eligible VC at or after in_ptr.
  always_comb begin
    int unsigned vidx;
    vidx = 0;
    for (int p = 0; p < PORT_NUM; p++) begin
      w_s1_valid[p] = 1'b0;
      w_s1_vc[p]    = '0;
      for (int k = 0; k < VC_NUM; k++) begin
        vidx = (int'(r_in_ptr[p]) + k) % VC_NUM;
        if (!w_s1_valid[p] && w_elig[p*VC_NUM + vidx]) begin
          w_s1_valid[p] = 1'b1;
          w_s1_vc[p]    = VC_SIZE'(vidx);
        end
      end
      w_s1_port[p] = out_port_i[(p*VC_NUM + int'(w_s1_vc[p]))*PORT_SIZE +: PORT_SIZE];
      w_s1_dv[p]   = downstream_vc_i[(p*VC_NUM + int'(w_s1_vc[p]))*VC_SIZE +: VC_SIZE];
    end
  end

  // Stage 2: per output, first stage-1 winner targeting it at or after out_ptr.
  always_comb begin
    int unsigned pidx;
    pidx     = 0;
    w_grant  = '0;
    w_xb_hit = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      w_xb_src[o] = '0;
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        pidx = (int'(r_out_ptr[o]) + k) % PORT_NUM;
        if (!w_xb_hit[o] && w_s1_valid[pidx] && (int'(w_s1_port[pidx]) == o)) begin
          w_xb_hit[o]    = 1'b1;
          w_xb_src[o]    = PORT_SIZE'(pidx);
          w_grant[pidx]  = 1'b1;
        end
      end
    end
  end

  // Outputs are gated by rst so an asserted reset clears them without a clock edge.
  always_comb begin
    valid_o    = '0;
    vc_sel_o   = '0;
    xb_valid_o = '0;
    xb_sel_o   = '0;
    xb_vc_o    = '0;
    if (rst) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        valid_o[p] = w_grant[p];
        vc_sel_o[p*VC_SIZE +: VC_SIZE] = w_grant[p] ? w_s1_vc[p] : r_in_ptr[p];
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        xb_valid_o[o] = w_xb_hit[o];
        xb_sel_o[o*PORT_SIZE +: PORT_SIZE] = w_xb_src[o];
        if (w_xb_hit[o]) begin
          xb_vc_o[o*VC_SIZE +: VC_SIZE] = w_s1_dv[w_xb_src[o]];
        end
      end
    end
  end

  // Pointers only move on a full grant, so a stage-2 loser keeps its VC priority.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      w_in_ptr_nxt[p] = w_grant[p] ? VC_SIZE'((int'(w_s1_vc[p]) + 1) % VC_NUM) : r_in_ptr[p];
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      w_out_ptr_nxt[o] = w_xb_hit[o] ? PORT_SIZE'((int'(w_xb_src[o]) + 1) % PORT_NUM)
                                     : r_out_ptr[o];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        r_in_ptr[p]  <= '0;
        r_out_ptr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < PORT_NUM; p++) begin
        r_in_ptr[p]  <= w_in_ptr_nxt[p];
        r_out_ptr[p] <= w_out_ptr_nxt[p];
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: the driver queues hand-computed expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_switch_allocator;

  localparam int unsigned PN = 5;
  localparam int unsigned VN = 2;
  localparam int unsigned VS = 1;
  localparam int unsigned PS = 3;

  logic              clk;
  logic              rst;
  logic [PN*VN-1:0]    request;
  logic [PN*VN*PS-1:0] out_port;
  logic [PN*VN*VS-1:0] dvc;
  logic [PN*VN-1:0]    on_off;
  logic [PN-1:0]       valid;
  logic [PN*VS-1:0]    vc_sel;
  logic [PN-1:0]       xb_valid;
  logic [PN*PS-1:0]    xb_sel;
  logic [PN*VS-1:0]    xb_vc;

  switch_allocator #(
    .PORT_NUM (PN),
    .VC_NUM   (VN),
    .VC_SIZE  (VS),
    .PORT_SIZE(PS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .request_i      (request),
    .out_port_i     (out_port),
    .downstream_vc_i(dvc),
    .on_off_i       (on_off),
    .valid_o        (valid),
    .vc_sel_o       (vc_sel),
    .xb_valid_o     (xb_valid),
    .xb_sel_o       (xb_sel),
    .xb_vc_o        (xb_vc)
  );

  typedef struct {
    string       name;
    logic [34:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [34:0] got;
      e   = sb.pop_front();
      got = {valid, vc_sel, xb_valid, xb_sel, xb_vc};
      checks++;
      if (got === e.exp) passes++;
      else $display("FAIL %s: got {v,vs,xv,xs,xc}=%b_%b_%b_%b_%b required %b_%b_%b_%b_%b",
                    e.name, got[34:30], got[29:25], got[24:20], got[19:5], got[4:0],
                    e.exp[34:30], e.exp[29:25], e.exp[24:20], e.exp[19:5], e.exp[4:0]);
    end
  end

  function automatic logic [14:0] sel(int s4, int s3, int s2, int s1, int s0);
    return {3'(s4), 3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  task automatic clr();
    request  = '0;
    out_port = '0;
    dvc      = '0;
    on_off   = '0;
  endtask

  task automatic req(int p, int v, int op, int dv);
    request[p*VN+v]            = 1'b1;
    out_port[(p*VN+v)*PS +: PS] = 3'(op);
    dvc[p*VN+v]                = 1'(dv);
  endtask

  task automatic on(int o, int v, logic val);
    on_off[o*VN+v] = val;
  endtask

  // Queue one cycle's expectation, then advance to just after the next rising edge.
  task automatic step(string name, logic [4:0] v, logic [4:0] vs, logic [4:0] xv,
                      logic [14:0] xs, logic [4:0] xc);
    exp_t e;
    e.name = name;
    e.exp  = {v, vs, xv, xs, xc};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    @(posedge clk);
    #1;

    // Reset with every request live: outputs held at zero, then pointers start at 0.
    for (int p = 0; p < PN; p++) begin
      for (int v = 0; v < VN; v++) begin
        req(p, v, p, v);
        on(p, v, 1'b1);
      end
    end
    step("rst_hold", 5'b00000, 5'b00000, 5'b00000, sel(0, 0, 0, 0, 0), 5'b00000);
    rst = 1'b1;
    step("rst_release", 5'b11111, 5'b00000, 5'b11111, sel(4, 3, 2, 1, 0), 5'b00000);

    // Output contention on port 4, including out_ptr wrap 4 -> 0.
    reset_dut();
    clr();
    req(1, 0, 4, 1);
    req(2, 0, 4, 1);
    req(3, 0, 4, 1);
    on(4, 1, 1'b1);
    step("cont_c0", 5'b00010, 5'b00000, 5'b10000, sel(1, 0, 0, 0, 0), 5'b10000);
    step("cont_c1", 5'b00100, 5'b00010, 5'b10000, sel(2, 0, 0, 0, 0), 5'b10000);
    step("cont_c2", 5'b01000, 5'b00110, 5'b10000, sel(3, 0, 0, 0, 0), 5'b10000);
    step("cont_wrap", 5'b00010, 5'b01100, 5'b10000, sel(1, 0, 0, 0, 0), 5'b10000);

    // VC fairness on input 2.
    reset_dut();
    clr();
    req(2, 0, 0, 0);
    req(2, 1, 3, 0);
    on(0, 0, 1'b1);
    on(3, 0, 1'b1);
    step("vcfair_c0", 5'b00100, 5'b00000, 5'b00001, sel(0, 0, 0, 0, 2), 5'b00000);
    step("vcfair_c1", 5'b00100, 5'b00100, 5'b01000, sel(0, 2, 0, 0, 0), 5'b00000);
    step("vcfair_c2", 5'b00100, 5'b00000, 5'b00001, sel(0, 0, 0, 0, 2), 5'b00000);

    // Backpressure: sole request blocked until on_off rises.
    reset_dut();
    clr();
    req(1, 1, 2, 0);
    on(2, 0, 1'b0);
    step("bp_off", 5'b00000, 5'b00000, 5'b00000, sel(0, 0, 0, 0, 0), 5'b00000);
    on(2, 0, 1'b1);
    step("bp_on", 5'b00010, 5'b00010, 5'b00100, sel(0, 0, 1, 0, 0), 5'b00000);

    // Out-of-range destination port is ineligible even with all on_off set.
    reset_dut();
    clr();
    req(3, 0, 7, 0);
    on_off = '1;
    step("oor_port", 5'b00000, 5'b00000, 5'b00000, sel(0, 0, 0, 0, 0), 5'b00000);

    // Stage-2 loss: build out_ptr[1]=4 and in_ptr[0]=1, then contend on output 1.
    reset_dut();
    clr();
    req(3, 0, 1, 0);
    req(0, 0, 0, 0);
    on(0, 0, 1'b1);
    on(1, 0, 1'b1);
    step("s2_setup", 5'b01001, 5'b00000, 5'b00011, sel(0, 0, 0, 3, 0), 5'b00000);
    clr();
    req(0, 0, 1, 0);
    req(0, 1, 1, 1);
    req(4, 0, 1, 0);
    on(1, 0, 1'b1);
    on(1, 1, 1'b1);
    step("s2_loss", 5'b10000, 5'b01001, 5'b00010, sel(0, 0, 0, 4, 0), 5'b00000);
    step("s2_retry", 5'b00001, 5'b11001, 5'b00010, sel(0, 0, 0, 0, 0), 5'b00010);

    // Async reset between edges while grants are active.
    rst = 1'b0;
    step("async_mid", 5'b00000, 5'b00000, 5'b00000, sel(0, 0, 0, 0, 0), 5'b00000);
    rst = 1'b1;
    step("async_after", 5'b00001, 5'b00000, 5'b00010, sel(0, 0, 0, 0, 0), 5'b00000);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
